cla_addsub_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 8-bit combinational CLA adder.
- Splits a WIDTH-bit add/sub into BLOCK-bit lookahead slices, one slice per pipeline stage, with the carry registered between stages.
- Throughput: one operation per cycle, with a valid/ready handshake on both sides.
- Consumers: the processor ALU and the multiply/divide units, which need wide add/sub without a full-width combinational carry path.

---
 rtl/cla_addsub_pipe.sv | 158 +++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// One BLOCK-bit lookahead slice is resolved per stage. The slice carry-out
// is registered between stages. A single global stall freezes every stage.
module cla_addsub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSTG = WIDTH / BLOCK;
  localparam int unsigned LAST = NSTG - 1;

  // Reject slice geometries the lookahead cannot build.
  if ((BLOCK < 1) || (BLOCK > 8) || ((WIDTH % BLOCK) != 0)) begin : g_bad_cfg
    $error("cla_addsub_pipe: WIDTH must be a multiple of BLOCK and BLOCK must be 1..8");
  end

  logic advance;

  // Combinational results of each stage: the values it hands to the next register.
  logic [WIDTH-1:0] nx_a  [NSTG];
  logic [WIDTH-1:0] nx_b  [NSTG];
  logic [WIDTH-1:0] nx_s  [NSTG];
  logic             nx_c  [NSTG];
  logic             nx_cm [NSTG];
  logic             nx_v  [NSTG];

  // Inter-stage registers. Index k holds the output of stage k, for k < LAST.
  logic [WIDTH-1:0] pa_q [NSTG];
  logic [WIDTH-1:0] pb_q [NSTG];
  logic [WIDTH-1:0] ps_q [NSTG];
  logic             pc_q [NSTG];
  logic             pv_q [NSTG];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_s;
    logic             in_c;
    logic             in_v;
    logic [BLOCK-1:0] sa;
    logic [BLOCK-1:0] sb;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             acc;
    logic             pp;
    logic [WIDTH-1:0] s_out;

    if (k == 0) begin : g_head
      // Stage 0 works directly on the accepted operands; subtract is A + ~B + 1.
      assign in_a = a;
      assign in_b = sub ? ~b : b;
      assign in_s = '0;
      assign in_c = sub;
      assign in_v = in_valid;
    end else begin : g_body
      assign in_a = pa_q[k-1];
      assign in_b = pb_q[k-1];
      assign in_s = ps_q[k-1];
      assign in_c = pc_q[k-1];
      assign in_v = pv_q[k-1];
    end

    assign sa = in_a[k*BLOCK +: BLOCK];
    assign sb = in_b[k*BLOCK +: BLOCK];
    assign g  = sa & sb;
    assign p  = sa | sb;

    // Flat two-level lookahead: each carry is a sum of generate/propagate products.
    always_comb begin
      c    = '0;
      acc  = 1'b0;
      pp   = 1'b0;
      c[0] = in_c;
      for (int i = 0; i < BLOCK; i++) begin
        acc = g[i];
        pp  = p[i];
        for (int j = i - 1; j >= 0; j--) begin
          acc = acc | (pp & g[j]);
          pp  = pp & p[j];
        end
        acc    = acc | (pp & in_c);
        c[i+1] = acc;
      end
    end

    // Merge this slice's sum bits into the partial result.
    always_comb begin
      s_out                    = in_s;
      s_out[k*BLOCK +: BLOCK]  = sa ^ sb ^ c[BLOCK-1:0];
    end

    assign nx_a[k]  = in_a;
    assign nx_b[k]  = in_b;
    assign nx_s[k]  = s_out;
    assign nx_c[k]  = c[BLOCK];
    assign nx_cm[k] = c[BLOCK-1];
    assign nx_v[k]  = in_v;
  end

  // Stage valid bits: cleared by reset, frozen while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NSTG; k++) pv_q[k] <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < LAST; k++) pv_q[k] <= nx_v[k];
    end
  end

  // Stage payloads: operands, partial sum and slice carry, frozen while stalled.
  always_ff @(posedge clock) begin
    if (advance) begin
      for (int k = 0; k < LAST; k++) begin
        pa_q[k] <= nx_a[k];
        pb_q[k] <= nx_b[k];
        ps_q[k] <= nx_s[k];
        pc_q[k] <= nx_c[k];
      end
    end
  end

  // Output stage: result and flags change only when a valid result arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= nx_v[LAST];
      if (nx_v[LAST]) begin
        sum  <= nx_s[LAST];
        cout <= nx_c[LAST];
        ovf  <= nx_c[LAST] ^ nx_cm[LAST];
        zero <= ~|nx_s[LAST];
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe at several WIDTH/BLOCK points.
module tb_cla_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
    bit          exact;
  } exp_t;

  function automatic int unsigned wsel(input int i);
    case (i)
      0:       return 32;
      1:       return 8;
      2:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int unsigned bsel(input int i);
    case (i)
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int unsigned W = wsel(gi);
    localparam int unsigned B = bsel(gi);
    localparam int unsigned L = W / B;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    exp_t         q[$];

    cla_addsub_pipe #(.WIDTH(W), .BLOCK(B)) dut (
      .clock    (clk),
      .reset    (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf),
      .zero     (zero)
    );

    task automatic ck(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] expv);
      chk(ok, $sformatf("w%0d/b%0d %s", W, B, nm), got, expv);
    endtask

    // Reference: plain unsigned and signed arithmetic on the true operand values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t                e;
      logic [W:0]          r;
      logic signed [W+1:0] sx;
      logic signed [W+1:0] sy;
      logic signed [W+1:0] sr;
      if (s) begin
        r      = {1'b0, x} - {1'b0, y};
        e.cout = (x >= y);
      end else begin
        r      = {1'b0, x} + {1'b0, y};
        e.cout = r[W];
      end
      sx      = (W+2)'($signed(x));
      sy      = (W+2)'($signed(y));
      sr      = s ? (sx - sy) : (sx + sy);
      e.ovf   = (sr != (W+2)'($signed(sr[W-1:0])));
      e.sum   = 64'(r[W-1:0]);
      e.zero  = (r[W-1:0] == '0);
      e.acc   = 0;
      e.exact = 1'b0;
      return e;
    endfunction

    function automatic logic [W-1:0] rnd();
      logic [W-1:0] v;
      logic [W-1:0] m;
      m       = '0;
      m[W-1]  = 1'b1;
      case ($urandom_range(0, 7))
        0:       v = '1;
        1:       v = m;
        default: v = W'({$urandom, $urandom});
      endcase
      return v;
    endfunction

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit ex);
      exp_t e;
      int   n;
      n        = 0;
      in_valid = 1'b1;
      a        = x;
      b        = y;
      sub      = s;
      forever begin
        @(negedge clk);
        if (in_ready === 1'b1) break;
        n++;
        if (n > 300) begin
          ck(1'b0, "in_ready timeout", 64'(in_ready), 64'd1);
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      e       = model(x, y, s);
      e.acc   = cyc + 1;
      e.exact = ex;
      q.push_back(e);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid === 1'b1) && n < 400) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 400) ck(1'b0, "drain timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) ck(1'b0, "out_valid timeout", 64'(out_valid), 64'd1);
    endtask

    // Monitor: pops on every handoff and checks hold-stability under stall.
    initial begin
      exp_t         e;
      bit           held;
      logic [W-1:0] h_sum;
      logic [2:0]   h_flags;
      held    = 1'b0;
      h_sum   = '0;
      h_flags = '0;
      forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
          held = 1'b0;
        end else begin
          if (held)
            ck(out_valid === 1'b1 && sum === h_sum && {cout, ovf, zero} === h_flags,
               "stall hold", 64'(sum), 64'(h_sum));
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
              ck(1'b0, "unexpected result", 64'(sum), 64'd0);
            end else begin
              e = q.pop_front();
              ck(64'(sum) === e.sum, "sum", 64'(sum), e.sum);
              ck({cout, ovf, zero} === {e.cout, e.ovf, e.zero}, "cout/ovf/zero",
                 64'({cout, ovf, zero}), 64'({e.cout, e.ovf, e.zero}));
              if (e.exact)
                ck(cyc - e.acc == int'(L) - 1, "latency", 64'(cyc - e.acc), 64'(L - 1));
              else
                ck(cyc - e.acc >= int'(L) - 1, "latency min", 64'(cyc - e.acc), 64'(L - 1));
            end
          end
          held    = (out_valid === 1'b1 && out_ready === 1'b0);
          h_sum   = sum;
          h_flags = {cout, ovf, zero};
        end
      end
    end

    // Driver: directed cases, streaming, backpressure, reset flush, random traffic.
    initial begin
      logic [W-1:0] msb;
      bit           rdone;
      int           n;
      msb       = '0;
      msb[W-1]  = 1'b1;
      rdone     = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ck(out_valid === 1'b0 && in_ready === 1'b1, "reset valid/ready",
         64'({out_valid, in_ready}), 64'b01);
      ck(sum === '0 && {cout, ovf, zero} === 3'b000, "reset data", 64'(sum), 64'd0);

      send(W'(64'hFF), W'(1), 1'b0, 1'b1); drain();
      send('1,          W'(1), 1'b0, 1'b1); drain();
      send(W'(5),       W'(7), 1'b1, 1'b1); drain();
      send(msb,         W'(1), 1'b1, 1'b1); drain();
      send(msb - W'(1), W'(1), 1'b0, 1'b1); drain();
      send(W'(9),       W'(9), 1'b1, 1'b1); drain();

      for (int i = 0; i < 8; i++)
        send(W'(i), W'(64'(i) * 64'h0101_0101), (i % 2) != 0, 1'b1);
      drain();

      fork
        begin
          for (int i = 0; i < 8; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
        end
        begin
          wait_valid();
          @(posedge clk);
          #1 out_ready = 1'b0;
          wait_valid();
          for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            ck(in_ready === 1'b0 && out_valid === 1'b1, "backpressure",
               64'({in_ready, out_valid}), 64'b01);
          end
          @(posedge clk);
          #1 out_ready = 1'b1;
        end
      join
      drain();

      for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      q.delete();
      ck(out_valid === 1'b0, "flush valid", 64'(out_valid), 64'd0);
      ck(sum === '0, "flush sum", 64'(sum), 64'd0);
      repeat (L + 2) @(posedge clk);
      #1;
      send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b1);
      drain();

      fork
        begin
          for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
              @(posedge clk);
              #1;
            end
            send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
          end
          rdone = 1'b1;
        end
        begin
          while (!rdone) begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 3) != 0);
          end
          out_ready = 1'b1;
        end
      join
      drain();
      ndone++;
    end
  end

  // Wait for every instance to finish, bounded, then report.
  initial begin
    int n;
    n = 0;
    while (ndone < 4 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (ndone < 4) chk(1'b0, "global timeout", 64'(ndone), 64'd4);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
